// File: rtl/spi_reg_slave8_if.sv
// 3-wire SPI pins between a bus master and the spi_reg_slave8 register slave.
interface spi_reg_slave8_if;
    logic spi_ce;
    logic spi_sclk;
    logic spi_sdi;
    logic spi_sdo;
    logic spi_sdo_oe;

    modport master (output spi_ce, spi_sclk, spi_sdi, input spi_sdo, spi_sdo_oe);
    modport slave  (input spi_ce, spi_sclk, spi_sdi, output spi_sdo, spi_sdo_oe);
endinterface

// File: rtl/spi_reg_slave8.sv
// SPI-to-register-file slave: 16-bit frames, 128 x 8 registers, oversampled SPI pins.
// Define SPI_SLAVE_READBACK_EN to drive read data back on spi_sdo; otherwise reads are consumed silently.
module spi_reg_slave8 #(
    parameter logic [6:0]  PLL_STATUS_ADDR = 7'h7E,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic            clk,
    input  logic            rst,
    spi_reg_slave8_if.slave spi,
    input  logic            pll_lock_in,
    input  logic [6:0]      reg_rd_addr,
    output logic [7:0]      reg_rd_data,
    output logic            wr_strobe,
    output logic [6:0]      wr_addr,
    output logic [7:0]      wr_data,
    output logic            frame_err,
    output logic [15:0]     wr_count
);
    localparam int unsigned AW   = 7;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 5;
    localparam int unsigned SW   = 14;
    localparam int unsigned NREG = 128;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] WDATA   = 3'd2;
    localparam logic [2:0] RDATA   = 3'd3;
    localparam logic [2:0] WAIT_CE = 3'd4;

    localparam logic [AW-1:0] ADDR_RSVD = 7'h7F;

    logic [SYNC_STAGES-1:0] ce_sync, sclk_sync, sdi_sync;
    logic [SYNC_STAGES:0]   fill;
    logic                   ce_q, sclk_q, armed;
    logic                   ce_s, sclk_s, sdi_s;
    logic                   ce_fall, sclk_rise, sclk_fall;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] bit_cnt;
    logic [SW-1:0] shreg;
    logic [SW:0]   shift_in;
    logic          in_frame, abort, commit, wr_ok;

    logic [DW-1:0] regs [NREG];

    assign ce_s   = ce_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // A frame may only open once ce has been seen high after reset, so a reset released mid-frame is ignored.
    assign ce_fall   = armed & ce_q & ~ce_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_sync   <= '1;
            sclk_sync <= '0;
            sdi_sync  <= '0;
            fill      <= '0;
            ce_q      <= 1'b1;
            sclk_q    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            ce_sync   <= {ce_sync[SYNC_STAGES-2:0], spi.spi_ce};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi.spi_sdi};
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
            ce_q      <= ce_s;
            sclk_q    <= sclk_s;
            armed     <= armed | (fill[SYNC_STAGES] & ce_s);
        end
    end

    // shift_in holds {addr[6:0], data[7:0]} at the 16th edge and {rw, addr} at the 8th.
    assign shift_in = {shreg, sdi_s};
    assign in_frame = (state == CMD) || (state == WDATA) || (state == RDATA);
    assign abort    = in_frame & ce_s & (bit_cnt != '0);
    assign commit   = (state == WDATA) && (state_nxt == WAIT_CE);
    assign wr_ok    = (shift_in[14:8] != ADDR_RSVD) && (shift_in[14:8] != PLL_STATUS_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != IDLE && ce_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:        if (ce_fall) state_nxt = CMD;
                CMD:         if (sclk_rise && bit_cnt == CW'(7)) state_nxt = shreg[6] ? RDATA : WDATA;
                WDATA, RDATA: if (sclk_rise && bit_cnt == CW'(15)) state_nxt = WAIT_CE;
                WAIT_CE:     state_nxt = WAIT_CE;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            wr_count  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= abort;
            if (state == IDLE && ce_fall) begin
                bit_cnt <= '0;
            end else if (in_frame && state_nxt != IDLE && sclk_rise) begin
                shreg   <= shift_in[SW-1:0];
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (commit && wr_ok) begin
                wr_strobe <= 1'b1;
                wr_addr   <= shift_in[14:8];
                wr_data   <= shift_in[7:0];
                wr_count  <= wr_count + 16'(1);
            end
        end
    end

    // Register file; the fabric read sees the pre-commit value in the commit cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (commit && wr_ok) begin
            regs[shift_in[14:8]] <= shift_in[7:0];
        end
    end

    assign reg_rd_data = regs[reg_rd_addr];

`ifdef SPI_SLAVE_READBACK_EN
    logic [DW-1:0] rd_byte;
    logic          sdo_q, oe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_byte <= '0;
            sdo_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            if (state == CMD && state_nxt == RDATA) begin
                rd_byte <= (shift_in[6:0] == PLL_STATUS_ADDR) ? {7'b0, pll_lock_in}
                                                              : regs[shift_in[6:0]];
            end else if (state == RDATA && state_nxt == RDATA && sclk_fall) begin
                oe_q    <= 1'b1;
                sdo_q   <= rd_byte[7];
                rd_byte <= {rd_byte[6:0], 1'b0};
            end
            if (state_nxt != RDATA) begin
                oe_q  <= 1'b0;
                sdo_q <= 1'b0;
            end
        end
    end

    assign spi.spi_sdo    = sdo_q;
    assign spi.spi_sdo_oe = oe_q;
`else
    logic unused_readback;
    assign unused_readback = pll_lock_in ^ sclk_fall;
    assign spi.spi_sdo    = 1'b0;
    assign spi.spi_sdo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_slave8.sv
// Directed bench for spi_reg_slave8: writes, reads, protected addresses, aborts and mid-frame reset.
module tb_spi_reg_slave8;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pll_lock_in = 1'b0;
    logic [6:0]  reg_rd_addr = '0;
    logic [7:0]  reg_rd_data;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;
    logic [15:0] wr_count;

    spi_reg_slave8_if spi_bus ();

    spi_reg_slave8 dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi_bus),
        .pll_lock_in (pll_lock_in),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_err   (frame_err),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    int          strobe_cnt = 0;
    int          err_cnt = 0;
    logic [6:0]  last_addr = '0;
    logic [7:0]  last_data = '0;
    logic [7:0]  rx;
    int          oe_cnt;
    int          sdo_hi;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ce_low();
        spi_bus.spi_ce = 1'b0;
        wait_clk(6);
    endtask

    task automatic ce_high();
        wait_clk(6);
        spi_bus.spi_ce = 1'b1;
        wait_clk(8);
    endtask

    // Drive bits [from, to) of f MSB first, sampling the returned line just before each rising edge.
    task automatic send_bits(input logic [15:0] f, input int from, input int to);
        for (int i = from; i < to; i++) begin
            spi_bus.spi_sdi = f[15-i];
            wait_clk(6);
            if (spi_bus.spi_sdo_oe === 1'b1) begin
                oe_cnt++;
                rx = {rx[6:0], spi_bus.spi_sdo};
            end
            if (spi_bus.spi_sdo === 1'b1) sdo_hi++;
            spi_bus.spi_sclk = 1'b1;
            wait_clk(6);
            spi_bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] f, input int n);
        rx = '0;
        oe_cnt = 0;
        sdo_hi = 0;
        ce_low();
        send_bits(f, 0, n);
        ce_high();
    endtask

    task automatic peek(input logic [6:0] a, input logic [7:0] exp, input string tag);
        reg_rd_addr = a;
        wait_clk(1);
        chk(tag, 32'(reg_rd_data), 32'(exp));
    endtask

    initial begin
        spi_bus.spi_ce   = 1'b1;
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_sdi  = 1'b0;
        wait_clk(4);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_sdo", 32'(spi_bus.spi_sdo), 32'd0);
        chk("rst_sdo_oe", 32'(spi_bus.spi_sdo_oe), 32'd0);
        peek(7'h05, 8'h00, "rst_reg05");
        rst = 1'b1;
        wait_clk(10);

        // Plain write
        frame(16'h05A5, 16);
        chk("w1_strobes", 32'(strobe_cnt), 32'd1);
        chk("w1_addr", 32'(last_addr), 32'h05);
        chk("w1_data", 32'(last_data), 32'hA5);
        chk("w1_count", 32'(wr_count), 32'd1);
        chk("w1_oe", 32'(oe_cnt), 32'd0);
        peek(7'h05, 8'hA5, "w1_reg05");

        // Write then read back
        frame(16'h103C, 16);
        chk("w2_strobes", 32'(strobe_cnt), 32'd2);
        peek(7'h10, 8'h3C, "w2_reg10");
        frame(16'h9000, 16);
`ifdef SPI_SLAVE_READBACK_EN
        chk("r1_data", 32'(rx), 32'h3C);
        chk("r1_oe_bits", 32'(oe_cnt), 32'd8);
`else
        chk("r1_oe_bits", 32'(oe_cnt), 32'd0);
        chk("r1_sdo_high", 32'(sdo_hi), 32'd0);
`endif
        chk("r1_oe_after", 32'(spi_bus.spi_sdo_oe), 32'd0);
        chk("r1_no_err", 32'(err_cnt), 32'd0);
        chk("r1_strobes", 32'(strobe_cnt), 32'd2);

        // Status address: readable, write-protected
        pll_lock_in = 1'b1;
        frame(16'hFE00, 16);
`ifdef SPI_SLAVE_READBACK_EN
        chk("pll_read", 32'(rx), 32'h01);
        chk("pll_oe_bits", 32'(oe_cnt), 32'd8);
`else
        chk("pll_oe_bits", 32'(oe_cnt), 32'd0);
`endif
        frame(16'h7E55, 16);
        chk("pll_wr_strobes", 32'(strobe_cnt), 32'd2);
        chk("pll_wr_count", 32'(wr_count), 32'd2);
        peek(7'h7E, 8'h00, "pll_reg7e");

        // Aborted frame after 10 edges, then a zero-edge frame, then recovery
        frame(16'h1234, 10);
        chk("abort_err", 32'(err_cnt), 32'd1);
        chk("abort_strobes", 32'(strobe_cnt), 32'd2);
        peek(7'h12, 8'h00, "abort_reg12");
        frame(16'h0000, 0);
        chk("zero_edge_err", 32'(err_cnt), 32'd1);
        frame(16'h2211, 16);
        chk("rec_strobes", 32'(strobe_cnt), 32'd3);
        chk("rec_addr", 32'(last_addr), 32'h22);
        chk("rec_data", 32'(last_data), 32'h11);
        chk("rec_count", 32'(wr_count), 32'd3);
        peek(7'h22, 8'h11, "rec_reg22");

        // Reserved address write
        frame(16'h7F00, 16);
        chk("rsvd_strobes", 32'(strobe_cnt), 32'd3);
        chk("rsvd_count", 32'(wr_count), 32'd3);

        // Reset in the middle of a frame; remainder of that frame must be ignored
        rx = '0;
        oe_cnt = 0;
        sdo_hi = 0;
        ce_low();
        send_bits(16'h3344, 0, 6);
        rst = 1'b0;
        wait_clk(4);
        chk("mid_rst_count", 32'(wr_count), 32'd0);
        chk("mid_rst_strobe", 32'(wr_strobe), 32'd0);
        chk("mid_rst_err", 32'(frame_err), 32'd0);
        chk("mid_rst_sdo", 32'(spi_bus.spi_sdo), 32'd0);
        chk("mid_rst_oe", 32'(spi_bus.spi_sdo_oe), 32'd0);
        peek(7'h05, 8'h00, "mid_rst_reg05");
        rst = 1'b1;
        wait_clk(4);
        send_bits(16'h3344, 6, 16);
        ce_high();
        chk("stale_strobes", 32'(strobe_cnt), 32'd3);
        chk("stale_err", 32'(err_cnt), 32'd1);
        peek(7'h33, 8'h00, "stale_reg33");
        frame(16'h3344, 16);
        chk("fresh_strobes", 32'(strobe_cnt), 32'd4);
        chk("fresh_addr", 32'(last_addr), 32'h33);
        chk("fresh_data", 32'(last_data), 32'h44);
        chk("fresh_count", 32'(wr_count), 32'd1);
        peek(7'h33, 8'h44, "fresh_reg33");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
